// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, read-only instruction cache.
// A lookup hit returns the addressed word in the same cycle. A miss stalls
// the fetch stage, reads the whole 8-word line from memory through a
// block-read handshake, then replays the lookup. Hit and miss counters
// saturate at 0xFFFF.
module icache_direct #(
    parameter int LINES = 16
) (
    input  logic         CLOCK,
    input  logic         RESET,
    input  logic [31:0]  Address_IN,
    input  logic         Read_IN,
    input  logic         Invalidate_IN,
    output logic [31:0]  Instruction_OUT,
    output logic         Stall_OUT,
    output logic [31:0]  BlockAddress_OUT,
    output logic         MemBlockRead_OUT,
    input  logic [255:0] InstructionBlock_IN,
    input  logic         BlockReady_IN,
    output logic [15:0]  HitCount_OUT,
    output logic [15:0]  MissCount_OUT
);

    localparam int IDX  = $clog2(LINES);
    localparam int TAGW = 27 - IDX;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_e;

    // Saturating 16-bit increment shared by both performance counters.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

    // Control state
    state_e            state_q,    state_d;
    logic [LINES-1:0]  valid_q,    valid_d;
    logic [31:0]       blk_addr_q, blk_addr_d;
    logic              mem_rd_q,   mem_rd_d;
    logic              pend_inv_q, pend_inv_d;
    logic [15:0]       hit_cnt_q,  hit_cnt_d;
    logic [15:0]       miss_cnt_q, miss_cnt_d;

    // Line storage (not reset; a line is only trusted once its valid bit is set)
    logic [255:0]      data_q [LINES];
    logic [TAGW-1:0]   tag_q  [LINES];

    // Lookup side (live fetch address)
    logic [2:0]        lk_off_s;
    logic [IDX-1:0]    lk_idx_s;
    logic [TAGW-1:0]   lk_tag_s;
    logic [255:0]      lk_line_s;
    logic              hit_s;

    // Fill side (latched miss address)
    logic [IDX-1:0]    fl_idx_s;
    logic [TAGW-1:0]   fl_tag_s;
    logic              fill_we_s;

    logic [31:0]       instr_s;
    logic              stall_s;

    // Byte-offset bits of the fetch address never select anything.
    logic              unused_addr_s;
    assign unused_addr_s = ^Address_IN[1:0];

    assign lk_off_s  = Address_IN[4:2];
    assign lk_idx_s  = Address_IN[5+IDX-1:5];
    assign lk_tag_s  = Address_IN[31:5+IDX];
    assign lk_line_s = data_q[lk_idx_s];
    assign fl_idx_s  = blk_addr_q[5+IDX-1:5];
    assign fl_tag_s  = blk_addr_q[31:5+IDX];

    // A hit only exists while idle; FILL never serves words.
    assign hit_s = (state_q == ST_IDLE) & Read_IN & valid_q[lk_idx_s]
                 & (tag_q[lk_idx_s] == lk_tag_s);

    // Next-state, lookup response and counter update.
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        blk_addr_d = blk_addr_q;
        mem_rd_d   = mem_rd_q;
        pend_inv_d = pend_inv_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        instr_s    = 32'h0000_0000;
        stall_s    = 1'b0;
        fill_we_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hit_s) begin
                    instr_s   = lk_line_s[{lk_off_s, 5'b00000} +: 32];
                    hit_cnt_d = sat_inc(hit_cnt_q);
                end else if (Read_IN) begin
                    stall_s    = 1'b1;
                    blk_addr_d = {Address_IN[31:5], 5'b00000};
                    mem_rd_d   = 1'b1;
                    miss_cnt_d = sat_inc(miss_cnt_q);
                    state_d    = ST_FILL;
                end else begin
                    stall_s = 1'b0;
                end
                // The lookup above already used the pre-clear valid bits.
                if (Invalidate_IN) begin
                    valid_d = '0;
                end else begin
                    valid_d = valid_q;
                end
            end
            ST_FILL: begin
                stall_s = 1'b1;
                if (Invalidate_IN) begin
                    pend_inv_d = 1'b1;
                end else begin
                    pend_inv_d = pend_inv_q;
                end
                if (BlockReady_IN) begin
                    fill_we_s          = 1'b1;
                    // An invalidate seen at any point of the fill leaves the line invalid.
                    valid_d[fl_idx_s]  = ~(pend_inv_q | Invalidate_IN);
                    pend_inv_d         = 1'b0;
                    mem_rd_d           = 1'b0;
                    state_d            = ST_IDLE;
                end else begin
                    fill_we_s = 1'b0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                mem_rd_d = 1'b0;
            end
        endcase
    end

    // Control registers; async reset also drops an in-flight block read at once.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_IDLE;
            valid_q    <= '0;
            blk_addr_q <= 32'h0000_0000;
            mem_rd_q   <= 1'b0;
            pend_inv_q <= 1'b0;
            hit_cnt_q  <= 16'h0000;
            miss_cnt_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            blk_addr_q <= blk_addr_d;
            mem_rd_q   <= mem_rd_d;
            pend_inv_q <= pend_inv_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Line data/tag write when a fill completes (state is IDLE under reset, so no write).
    always_ff @(posedge CLOCK) begin
        if (fill_we_s) begin
            data_q[fl_idx_s] <= InstructionBlock_IN;
            tag_q[fl_idx_s]  <= fl_tag_s;
        end
    end

    assign Instruction_OUT  = instr_s;
    assign Stall_OUT        = stall_s;
    assign BlockAddress_OUT = blk_addr_q;
    assign MemBlockRead_OUT = mem_rd_q;
    assign HitCount_OUT     = hit_cnt_q;
    assign MissCount_OUT    = miss_cnt_q;

endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct: directed plus randomized fetch traffic for icache_direct,
// checked against a cache model kept as per-index (valid, line address) pairs
// and a memory whose contents are a fixed function of the line address.
module tb_icache_direct;

    logic         CLOCK;
    logic         RESET;
    logic [31:0]  Address_IN;
    logic         Read_IN;
    logic         Invalidate_IN;
    logic [31:0]  Instruction_OUT;
    logic         Stall_OUT;
    logic [31:0]  BlockAddress_OUT;
    logic         MemBlockRead_OUT;
    logic [255:0] InstructionBlock_IN;
    logic         BlockReady_IN;
    logic [15:0]  HitCount_OUT;
    logic [15:0]  MissCount_OUT;

    icache_direct #(.LINES(16)) dut (
        .CLOCK               (CLOCK),
        .RESET               (RESET),
        .Address_IN          (Address_IN),
        .Read_IN             (Read_IN),
        .Invalidate_IN       (Invalidate_IN),
        .Instruction_OUT     (Instruction_OUT),
        .Stall_OUT           (Stall_OUT),
        .BlockAddress_OUT    (BlockAddress_OUT),
        .MemBlockRead_OUT    (MemBlockRead_OUT),
        .InstructionBlock_IN (InstructionBlock_IN),
        .BlockReady_IN       (BlockReady_IN),
        .HitCount_OUT        (HitCount_OUT),
        .MissCount_OUT       (MissCount_OUT)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model
    bit          ref_valid [16];
    logic [31:0] ref_line  [16];
    logic [15:0] ref_hits;
    logic [15:0] ref_misses;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    function automatic logic [15:0] sat(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Memory contents: the 0x00400000 line holds 0x1000+k, others are address-derived.
    function automatic logic [31:0] blk_word(input logic [31:0] line, input int k);
        if (line == 32'h0040_0000) return 32'h0000_1000 + 32'(k);
        return (line ^ 32'hC0DE_0000) + 32'(k) + 32'd1;
    endfunction

    function automatic logic [255:0] blk_line(input logic [31:0] line);
        logic [255:0] b;
        for (int k = 0; k < 8; k++) b[32*k +: 32] = blk_word(line, k);
        return b;
    endfunction

    function automatic bit ref_hit(input logic [31:0] a);
        int idx;
        idx = int'(a[8:5]);
        return ref_valid[idx] && (ref_line[idx] == {a[31:5], 5'b00000});
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
        ref_hits   = 16'h0000;
        ref_misses = 16'h0000;
    endtask

    task automatic check_counters(input string tag);
        chk({tag, "_hits"},   32'(HitCount_OUT),  32'(ref_hits));
        chk({tag, "_misses"}, 32'(MissCount_OUT), 32'(ref_misses));
    endtask

    // One fetch; on a miss the memory answers after 'lat' extra FILL cycles.
    task automatic fetch(input logic [31:0] a, input int lat, input bit inv_mid);
        logic [31:0] line;
        int idx;
        int off;
        line = {a[31:5], 5'b00000};
        idx  = int'(a[8:5]);
        off  = int'(a[4:2]);
        Read_IN    = 1'b1;
        Address_IN = a;
        #1;
        if (ref_hit(a)) begin
            chk("hit_stall", 32'(Stall_OUT), 32'd0);
            chk("hit_word", Instruction_OUT, blk_word(line, off));
            ref_hits = sat(ref_hits);
            tick();
        end else begin
            chk("miss_stall", 32'(Stall_OUT), 32'd1);
            chk("miss_word", Instruction_OUT, 32'd0);
            tick();
            ref_misses = sat(ref_misses);
            for (int c = 0; c <= lat; c++) begin
                Address_IN          = $urandom;
                Invalidate_IN       = inv_mid && (c == 0);
                BlockReady_IN       = (c == lat);
                InstructionBlock_IN = (c == lat) ? blk_line(line) : {8{$urandom}};
                #1;
                chk("fill_rd", 32'(MemBlockRead_OUT), 32'd1);
                chk("fill_addr", BlockAddress_OUT, line);
                chk("fill_stall", 32'(Stall_OUT), 32'd1);
                chk("fill_word", Instruction_OUT, 32'd0);
                tick();
            end
            BlockReady_IN       = 1'b0;
            Invalidate_IN       = 1'b0;
            InstructionBlock_IN = {8{$urandom}};
            Address_IN          = a;
            ref_line[idx]       = line;
            ref_valid[idx]      = !inv_mid;
            #1;
            chk("done_rd", 32'(MemBlockRead_OUT), 32'd0);
            if (ref_valid[idx]) begin
                chk("replay_stall", 32'(Stall_OUT), 32'd0);
                chk("replay_word", Instruction_OUT, blk_word(line, off));
                ref_hits = sat(ref_hits);
                tick();
            end else begin
                chk("replay_miss_stall", 32'(Stall_OUT), 32'd1);
                Read_IN = 1'b0;
                tick();
            end
        end
        Read_IN = 1'b0;
    endtask

    task automatic inv_idle();
        Read_IN       = 1'b0;
        Invalidate_IN = 1'b1;
        #1;
        chk("inv_stall", 32'(Stall_OUT), 32'd0);
        tick();
        Invalidate_IN = 1'b0;
        for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
    endtask

    task automatic stray();
        Read_IN             = 1'b0;
        Address_IN          = $urandom;
        BlockReady_IN       = 1'b1;
        InstructionBlock_IN = {8{$urandom}};
        #1;
        chk("stray_stall", 32'(Stall_OUT), 32'd0);
        chk("stray_word", Instruction_OUT, 32'd0);
        tick();
        BlockReady_IN = 1'b0;
        chk("stray_rd", 32'(MemBlockRead_OUT), 32'd0);
        check_counters("stray");
    endtask

    initial begin
        logic [31:0] a;
        int lat;
        bit inv;
        int r;

        RESET               = 1'b0;
        Address_IN          = 32'h0;
        Read_IN             = 1'b0;
        Invalidate_IN       = 1'b0;
        InstructionBlock_IN = '0;
        BlockReady_IN       = 1'b0;
        model_reset();
        #12;
        chk("rst_rd", 32'(MemBlockRead_OUT), 32'd0);
        chk("rst_baddr", BlockAddress_OUT, 32'd0);
        chk("rst_stall", 32'(Stall_OUT), 32'd0);
        check_counters("rst");
        tick();
        RESET = 1'b1;
        tick();

        // Cold miss, minimum penalty, then the rest of the line hits
        fetch(32'h0040_0000, 0, 1'b0);
        for (int k = 1; k < 8; k++) fetch(32'h0040_0000 + 32'(4 * k), 0, 1'b0);
        chk("cold_hits", 32'(HitCount_OUT), 32'd8);
        chk("cold_misses", 32'(MissCount_OUT), 32'd1);

        // Conflict eviction on index 0
        fetch(32'h0040_0200, 1, 1'b0);
        fetch(32'h0040_0000, 2, 1'b0);
        fetch(32'h0040_0008, 0, 1'b0);
        chk("evict_misses", 32'(MissCount_OUT), 32'd3);
        check_counters("evict");

        // Invalidate in IDLE with a same-cycle lookup that still hits
        Read_IN       = 1'b1;
        Address_IN    = 32'h0040_0004;
        Invalidate_IN = 1'b1;
        #1;
        chk("inv_hit_word", Instruction_OUT, 32'h0000_1001);
        chk("inv_hit_stall", 32'(Stall_OUT), 32'd0);
        ref_hits = sat(ref_hits);
        tick();
        Invalidate_IN = 1'b0;
        Read_IN       = 1'b0;
        for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
        fetch(32'h0040_0004, 1, 1'b0);
        check_counters("inv_idle");

        // Invalidate during FILL: data lands but line stays invalid
        fetch(32'h0040_0040, 2, 1'b1);
        fetch(32'h0040_0040, 0, 1'b0);
        check_counters("inv_fill");

        // Stray handshake while idle
        stray();
        fetch(32'h0040_0060, 0, 1'b0);

        // Reset in the middle of a fill
        inv_idle();
        Read_IN    = 1'b1;
        Address_IN = 32'h0040_0100;
        tick();
        chk("rstfill_rd_before", 32'(MemBlockRead_OUT), 32'd1);
        #2;
        RESET = 1'b0;
        #1;
        chk("rstfill_rd_now", 32'(MemBlockRead_OUT), 32'd0);
        model_reset();
        check_counters("rstfill");
        Read_IN = 1'b0;
        tick();
        RESET               = 1'b1;
        BlockReady_IN       = 1'b1;
        InstructionBlock_IN = blk_line(32'h0040_0100);
        #1;
        chk("rstfill_stray_stall", 32'(Stall_OUT), 32'd0);
        tick();
        BlockReady_IN = 1'b0;
        fetch(32'h0040_0100, 1, 1'b0);
        check_counters("rstfill_reread");

        // Randomized traffic over three conflicting tags
        for (int it = 0; it < 120; it++) begin
            r = $urandom_range(0, 11);
            if (r == 0) begin
                inv_idle();
            end else if (r == 1) begin
                stray();
            end else begin
                a   = 32'h0040_0000 + 32'($urandom_range(0, 2)) * 32'h200
                    + 32'($urandom_range(0, 15)) * 32'd32 + 32'($urandom_range(0, 31));
                lat = $urandom_range(0, 3);
                inv = (lat > 0) && ($urandom_range(0, 7) == 0);
                fetch(a, lat, inv);
            end
            check_counters("rand");
        end

        // Hit counter saturation
        fetch(32'h0040_0000, 0, 1'b0);
        Read_IN    = 1'b1;
        Address_IN = 32'h0040_0004;
        #1;
        chk("sat_word", Instruction_OUT, 32'h0000_1001);
        repeat (65600) tick();
        Read_IN = 1'b0;
        ref_hits = 16'hFFFF;
        #1;
        chk("sat_hits", 32'(HitCount_OUT), 32'h0000_FFFF);
        check_counters("sat");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_direct.md
# icache_direct

Direct-mapped, read-only instruction cache between the pipeline's IF stage and the instruction memory's 256-bit block-read port. A hit returns the addressed 32-bit word combinationally in the same cycle. A miss stalls IF, fetches the whole 8-word line through a block-read handshake, and then replays the lookup. Hit and miss performance counters are included.

## Interface
Parameters:
- LINES, 16, number of cache lines; power of two, ≥2. IDX = log2(LINES).

Ports:
- CLOCK  in  1  rising-edge clock
- RESET  in  1  asynchronous, active-low reset (0 = reset)
- Address_IN  in  32  fetch address from IF; bits [1:0] ignored
- Read_IN  in  1  fetch request valid this cycle
- Invalidate_IN  in  1  clear all valid bits
- Instruction_OUT  out  32  fetched word; 0x00000000 when not a hit
- Stall_OUT  out  1  IF/IFID must hold; Address_IN stays stable while high
- BlockAddress_OUT  out  32  line-aligned miss address
- MemBlockRead_OUT  out  1  block read request to memory
- InstructionBlock_IN  in  256  returned line; word k = bits [32k+31:32k]
- BlockReady_IN  in  1  InstructionBlock_IN valid (single-cycle pulse)
- HitCount_OUT  out  16  saturating hit counter
- MissCount_OUT  out  16  saturating miss counter

## Operation
- Address split: word offset = [4:2]; index = [5+IDX-1:5]; tag = [31:5+IDX].
- Storage per line: valid bit, tag, and 256-bit data.
- FSM states are IDLE and FILL.
- IDLE behaviour:
  - hit = Read_IN & valid[index] & (tag match).
  - On a hit: Instruction_OUT = data[index] word[offset]; Stall_OUT = 0.
  - On Read_IN & ~hit (miss): Stall_OUT = 1 combinationally. At the next edge: latch BlockAddress_OUT = {Address_IN[31:5], 5'b0}, set MemBlockRead_OUT = 1, enter FILL.
  - Read_IN = 0: Stall_OUT = 0, Instruction_OUT = 0, no state change.
- FILL behaviour:
  - Stall_OUT = 1 and Instruction_OUT = 0.
  - MemBlockRead_OUT and BlockAddress_OUT hold steady until BlockReady_IN is sampled high.
  - At the edge where BlockReady_IN = 1: write data[line] = InstructionBlock_IN and tag[line] = latched tag; set valid[line] = 1 unless an invalidate is pending; clear MemBlockRead_OUT; return to IDLE.
  - Address_IN is ignored during FILL; the line is taken from the latched address.
- Invalidate_IN:
  - In IDLE: all valid bits clear at the next edge. A lookup in the same cycle still uses the pre-clear contents.
  - In FILL: sets a pending flag. The completing fill writes data and tag but leaves valid = 0. The flag clears when the fill completes.
- BlockReady_IN while in IDLE is ignored.
- Counters:
  - HitCount_OUT +1 on every IDLE cycle with hit.
  - MissCount_OUT +1 on every IDLE→FILL transition.
  - Both saturate at 0xFFFF.

## Timing
- Hit latency is 0 cycles: the word is valid in the same cycle as Address_IN/Read_IN.
- Miss sequence:
  - cycle 0: miss detected, Stall_OUT = 1.
  - cycle 1: FILL, MemBlockRead_OUT = 1.
  - cycle N: BlockReady_IN = 1.
  - cycle N+1: IDLE, re-lookup hits and Stall_OUT = 0.
- Minimum miss penalty is 2 stall cycles, when BlockReady_IN arrives in cycle 1.
- Reset values (RESET = 0, asynchronous):
  - FSM = IDLE; all valid bits = 0; pending-invalidate flag = 0.
  - MemBlockRead_OUT = 0; BlockAddress_OUT = 0; HitCount_OUT = 0; MissCount_OUT = 0.
  - Data and tag arrays need not be reset.
- Reset during FILL aborts the fill: MemBlockRead_OUT drops without waiting for a clock edge, and no line is written.
- After reset release, the first Read_IN always misses.

## Test plan
- Cold miss and fill:
  - Stimulus: reset; Read 0x00400000; one cycle later supply a block with words 0x1000+k and pulse BlockReady_IN.
  - Required response: BlockAddress_OUT = 0x00400000; Stall_OUT high for 2 cycles; then Instruction_OUT = 0x1000. Sequential reads 0x00400004–0x0040001C return 0x1001–0x1007 with zero stalls. HitCount = 8, MissCount = 1.
- Conflict eviction (LINES = 16):
  - Stimulus: 0x00400000, then 0x00400200 (same index), then 0x00400000 again.
  - Required response: three misses, MissCount = 3, and the second fill of 0x00400000 returns the correct data.
- Invalidate in IDLE:
  - Stimulus: after a fill, pulse Invalidate_IN, then re-read the same address.
  - Required response: miss, MemBlockRead_OUT = 1.
- Invalidate during FILL:
  - Stimulus: pulse Invalidate_IN mid-fill, complete the fill.
  - Required response: the next lookup of that address misses again.
- Reset mid-FILL:
  - Stimulus: assert RESET between MemBlockRead_OUT rising and BlockReady_IN.
  - Required response: MemBlockRead_OUT = 0 immediately; counters = 0; a later BlockReady_IN is ignored; the re-read misses.
- Idle / stray handshake:
  - Stimulus: Read_IN = 0 with BlockReady_IN pulsed.
  - Required response: Stall_OUT = 0, Instruction_OUT = 0, counters unchanged, no valid bits set.
- Counter saturation:
  - Stimulus: force more than 65535 hits.
  - Required response: HitCount_OUT holds at 0xFFFF.
